serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter: N, default 4, operand/result width in bits (legal range 2..16).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: resetn  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request to begin a subtraction; sampled on rising clk.
REQ-006 Port: a  input  N  minuend, unsigned.
REQ-007 Port: b  input  N  subtrahend, unsigned.
REQ-008 Port: bin  input  1  borrow-in.
REQ-009 Port: busy  output  1  high while a subtraction is in progress.
REQ-010 Port: done  output  1  single-cycle pulse when the result becomes valid.
REQ-011 Port: diff  output  N  result a - b - bin, modulo 2^N.
REQ-012 Port: bout  output  1  final borrow-out; high when a < b + bin (unsigned).

Function
REQ-013 States SHALL be IDLE, RUN and DONE, encoded with 2 bits.
REQ-014 In IDLE, start=1 at edge t0 SHALL latch a, b and bin, clear the bit counter, and enter RUN with busy=1 after t0.
REQ-015 In RUN, each edge SHALL process one bit, LSB first, through one full-subtractor stage.
  - d = x^y^br
  - br_next = (~x & y) | (~(x^y) & br)
  - d shifts into the result register from the MSB end.
REQ-016 RUN SHALL last exactly N edges (t1..tN); after tN the state is DONE.
REQ-017 In DONE:
  - done=1 and busy=0 for exactly one cycle;
  - diff and bout hold the final values;
  - the next edge returns to IDLE.
REQ-018 diff and bout SHALL hold their last completed values through IDLE until the next completion.
REQ-019 diff and bout SHALL NOT change during RUN; the internal shift register is separate from the output registers.
REQ-020 start SHALL be ignored in RUN and DONE; no queuing.
REQ-021 a, b and bin SHALL be ignored except at the accepting edge.
REQ-022 Latency SHALL be N+1 cycles from the accepting edge to the done pulse; maximum throughput is one result per N+2 cycles.
REQ-023 start held high continuously SHALL start a new operation at each return to IDLE.

Reset
REQ-024 resetn=0 SHALL immediately force:
  - state=IDLE
  - busy=0, done=0
  - diff=0, bout=0
  - shift registers, borrow flop and counter all zero.
REQ-025 Reset asserted mid-RUN SHALL abort the operation; no done pulse follows reset release.
REQ-026 The first start after reset release SHALL be accepted normally.

Structure
REQ-027 The state encoding constants and the default width SHALL live in a shared package, arith_pkg.
REQ-028 The one-bit stage SHALL be a sub-module, full_subtractor, with ports x, y, bin, d, bout; it is purely combinational.
REQ-029 The counter width SHALL be $clog2(N)+1 bits.

Verification
REQ-030 N=4, a=9, b=3, bin=0, start pulse -> after 5 cycles done=1, diff=6, bout=0; busy high for exactly 4 cycles.
REQ-031 N=4, a=3, b=9, bin=0 -> diff=10 (4'b1010), bout=1.
REQ-032 N=4, a=0, b=0, bin=1 -> diff=15, bout=1. Also a=15, b=15, bin=0 -> diff=0, bout=0.
REQ-033 start re-pulsed with a=1, b=1 at cycle 2 of RUN, original a=9, b=3 -> the first result is unchanged (6); no second done pulse without a new start in IDLE.
REQ-034 resetn pulsed low at cycle 2 of RUN -> busy, done, diff and bout are 0 immediately; no done pulse follows; a subsequent a=7, b=2 yields diff=5.
REQ-035 start held high with a=12, b=5 -> done pulses every 6 cycles with diff=7; diff is stable between pulses.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: default operand width
// and the controller state encoding.
package arith_pkg;

  localparam int unsigned N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor. The master issues operands and
// start; the slave (the subtractor) reports busy/done and the result.
interface serial_subtractor_if
  import arith_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout set when x < y + bin.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first.
// Operands are captured on the accepting edge; the result registers only
// update on the final bit, so diff/bout stay stable while a run is active.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input logic                clk,
  input logic                resetn,
  serial_subtractor_if.slave bus
);

  localparam int unsigned    CW   = $clog2(N) + 1;
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  sh_a;
  logic [N-1:0]  sh_b;
  logic [N-1:0]  sh_res;
  logic [N-1:0]  diff_q;
  logic          br;
  logic          bout_q;
  logic [CW-1:0] cnt;
  logic          d_bit;
  logic          br_bit;

  full_subtractor u_fs (
    .x    (sh_a[0]),
    .y    (sh_b[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state: accept in IDLE, run N bits, one cycle in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, per-bit shifting, and result commit on the last bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh_a   <= '0;
      sh_b   <= '0;
      sh_res <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sh_a   <= bus.a;
            sh_b   <= bus.b;
            br     <= bus.bin;
            sh_res <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          sh_a   <= sh_a >> 1;
          sh_b   <= sh_b >> 1;
          br     <= br_bit;
          sh_res <= {d_bit, sh_res[N-1:1]};
          cnt    <= cnt + 1'b1;
          // Final bit: commit the fully shifted result straight to the outputs.
          if (cnt == LAST) begin
            diff_q <= {d_bit, sh_res[N-1:1]};
            bout_q <= br_bit;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (N=4). Stimulus pushes expected
// {bout, diff} into a queue; a monitor pops on each done pulse and compares.
module tb_serial_subtractor;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  serial_subtractor_if #(.N(N)) bus ();

  serial_subtractor #(.N(N)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [N:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: sampled 1 time unit after each rising edge.
  initial begin
    logic [N-1:0] last_diff;
    logic         last_bout;
    logic [N:0]   e;
    int           busy_cnt;
    last_diff = '0;
    last_bout = 1'b0;
    busy_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (resetn !== 1'b1) begin
        busy_cnt  = 0;
        last_diff = '0;
        last_bout = 1'b0;
      end else if (bus.done === 1'b1) begin
        check("busy_len", busy_cnt, N);
        check("busy_in_done", bus.busy, 0);
        busy_cnt = 0;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=1, expected no done (diff=%0d)", bus.diff);
        end else begin
          e = exp_q.pop_front();
          check("diff", bus.diff, e[N-1:0]);
          check("bout", bus.bout, e[N]);
        end
        last_diff = bus.diff;
        last_bout = bus.bout;
      end else begin
        if (bus.busy === 1'b1) busy_cnt++;
        check("diff_hold", bus.diff, last_diff);
        check("bout_hold", bus.bout, last_bout);
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while ((bus.busy !== 1'b0 || bus.done !== 1'b0) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got busy=%0d done=%0d, expected idle", bus.busy, bus.done);
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (bus.done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got done=%0d, expected 1", bus.done);
    end
  endtask

  // Issue one start pulse; returns at the negedge after the accepting edge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                       input logic [N-1:0] exp_d, input logic exp_bo, input bit push);
    @(negedge clk);
    wait_idle();
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    if (push) exp_q.push_back({exp_bo, exp_d});
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.bin   = ~bin;
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                        input logic [N-1:0] exp_d, input logic exp_bo);
    issue(a, b, bin, exp_d, exp_bo, 1'b1);
    wait_done();
  endtask

  initial begin
    int ndone;
    int cyc;
    int last_cyc;
    int k;

    resetn    = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_diff", bus.diff, 0);
    check("rst_bout", bus.bout, 0);
    resetn = 1'b1;

    run_op(4'd9,  4'd3,  1'b0, 4'd6,  1'b0);
    run_op(4'd3,  4'd9,  1'b0, 4'd10, 1'b1);
    run_op(4'd0,  4'd0,  1'b1, 4'd15, 1'b1);
    run_op(4'd15, 4'd15, 1'b0, 4'd0,  1'b0);
    run_op(4'd8,  4'd1,  1'b1, 4'd6,  1'b0);
    run_op(4'd0,  4'd15, 1'b1, 4'd0,  1'b1);

    // Start re-pulsed during RUN must be ignored.
    issue(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 4'd1;
    bus.b     = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);

    // Leave bout=1 and a nonzero diff so the reset clear is observable.
    run_op(4'd5, 4'd6, 1'b0, 4'd15, 1'b1);

    // Reset in cycle 2 of RUN aborts without a done pulse.
    issue(4'd9, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_diff", bus.diff, 0);
    check("abort_bout", bus.bout, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    run_op(4'd7, 4'd2, 1'b0, 4'd5, 1'b0);

    // Start held high: back-to-back operations every N+2 cycles.
    @(negedge clk);
    wait_idle();
    bus.start = 1'b1;
    bus.a     = 4'd12;
    bus.b     = 4'd5;
    bus.bin   = 1'b0;
    repeat (3) exp_q.push_back({1'b0, 4'd7});
    ndone    = 0;
    cyc      = 0;
    last_cyc = 0;
    while (ndone < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) begin
        if (ndone > 0) check("done_gap", cyc - last_cyc, N + 2);
        last_cyc = cyc;
        ndone++;
        if (ndone == 3) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    if (ndone < 3) begin
      vectors++;
      miscompares++;
      $display("FAIL hold_timeout: got %0d done pulses, expected 3", ndone);
    end
    repeat (10) @(negedge clk);

    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
